// File: rtl/adder_pipe_if.sv
// Operand/result handshake bundle for adder_pipe.
// The producer and consumer side share the master modport; the adder itself is the slave.
interface adder_pipe_if #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_sum;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_b, in_sub, in_tag, out_ready,
        input  in_ready, out_valid, out_sum, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_tag, out_ready,
        output in_ready, out_valid, out_sum, out_tag
    );
endinterface

// File: rtl/adder_pipe.sv
// Pipelined unsigned add/sub: the carry chain is cut into SEG_W-bit segments, one register per segment,
// with a single global stall so the whole pipe freezes while the output is held.
module adder_pipe #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned SEG_W = 4,
    parameter int unsigned TAG_W = 4
) (
    input logic        clk,
    input logic        rst,
    adder_pipe_if.slave bus
);
    localparam int unsigned STAGES = (WIDTH + SEG_W - 1) / SEG_W;

    logic advance;

    assign advance = !bus.out_valid || bus.out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned LO   = k * SEG_W;
        localparam int unsigned HI   = ((k + 1) * SEG_W < WIDTH) ? (k + 1) * SEG_W - 1 : WIDTH - 1;
        localparam int unsigned SW   = HI - LO + 1;
        localparam logic [WIDTH:0]   ONES = ((WIDTH + 1)'(1) << SW) - (WIDTH + 1)'(1);
        localparam logic [WIDTH-1:0] MASK = WIDTH'(ONES << LO);
        localparam bit LAST = (k == STAGES - 1);

        logic             src_v;
        logic             src_c;
        logic             src_sub;
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;
        logic [WIDTH-1:0] src_sum;
        logic [TAG_W-1:0] src_tag;
        logic [WIDTH:0]   seg;
        logic             carry;

        logic             v;
        logic             c;
        logic [WIDTH-1:0] sum;
        logic [TAG_W-1:0] tag;

        // Stage 0 takes the raw operation; B is inverted and carry-in set for subtraction
        if (k == 0) begin : g_src
            assign src_v   = bus.in_valid;
            assign src_c   = bus.in_sub;
            assign src_sub = bus.in_sub;
            assign src_a   = bus.in_a;
            assign src_b   = bus.in_b ^ {WIDTH{bus.in_sub}};
            assign src_sum = '0;
            assign src_tag = bus.in_tag;
        end else begin : g_src
            assign src_v   = g_stage[k-1].v;
            assign src_c   = g_stage[k-1].c;
            assign src_sub = g_stage[k-1].g_fwd.sub;
            assign src_a   = g_stage[k-1].g_fwd.a;
            assign src_b   = g_stage[k-1].g_fwd.b;
            assign src_sum = g_stage[k-1].sum;
            assign src_tag = g_stage[k-1].tag;
        end

        // Masked segment add; only bits [HI+1:LO] can be non-zero, bit HI+1 is the segment carry
        assign seg   = {1'b0, src_a & MASK} + {1'b0, src_b & MASK} + ((WIDTH + 1)'(src_c) << LO);
        assign carry = 1'(seg >> (HI + 1));

        // The last stage folds the borrow correction into the stored carry so out_sum is pure register
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v   <= 1'b0;
                c   <= 1'b0;
                sum <= '0;
                tag <= '0;
            end else if (advance) begin
                v   <= src_v;
                c   <= LAST ? (carry ^ src_sub) : carry;
                sum <= (src_sum & ~MASK) | (seg[WIDTH-1:0] & MASK);
                tag <= src_tag;
            end
        end

        if (!LAST) begin : g_fwd
            logic [WIDTH-1:0] a;
            logic [WIDTH-1:0] b;
            logic             sub;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a   <= '0;
                    b   <= '0;
                    sub <= 1'b0;
                end else if (advance) begin
                    a   <= src_a;
                    b   <= src_b;
                    sub <= src_sub;
                end
            end
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = g_stage[STAGES-1].v;
    assign bus.out_sum   = {g_stage[STAGES-1].c, g_stage[STAGES-1].sum};
    assign bus.out_tag   = g_stage[STAGES-1].tag;
endmodule

// File: tb/tb_adder_pipe.sv
// Scoreboard bench for adder_pipe: default instance plus a (WIDTH,SEG_W) sweep, all checked
// against an independent arithmetic model.
module tb_adder_pipe;
    localparam int NINST = 5;

    typedef struct {
        logic [63:0] sum;
        logic [63:0] tag;
        int unsigned cyc;
        bit          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    int unsigned cyc    = 0;

    logic        drv_v    [NINST];
    logic        drv_sub  [NINST];
    logic        drv_ordy [NINST];
    logic        drv_lrst [NINST];
    logic [63:0] drv_a    [NINST];
    logic [63:0] drv_b    [NINST];
    logic [63:0] drv_tag  [NINST];
    logic        mon_iready [NINST];
    logic        mon_ov     [NINST];
    logic [63:0] mon_sum    [NINST];
    logic [63:0] mon_tag    [NINST];

    exp_t        q[$];
    bit          hold_prev = 1'b0;
    logic [63:0] prev_sum  = '0;
    logic [63:0] prev_tag  = '0;

    always #5 clk = ~clk;

    function automatic int unsigned cfg_w(input int g);
        case (g)
            3:       return 16;
            4:       return 1;
            default: return 11;
        endcase
    endfunction

    function automatic int unsigned cfg_s(input int g);
        case (g)
            0:       return 4;
            1:       return 11;
            2:       return 1;
            3:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int unsigned cfg_t(input int g);
        return (g == 0) ? 4 : 8;
    endfunction

    function automatic int unsigned cfg_stg(input int g);
        return (cfg_w(g) + cfg_s(g) - 1) / cfg_s(g);
    endfunction

    function automatic logic [63:0] wmask(input int g);
        return (64'd1 << cfg_w(g)) - 64'd1;
    endfunction

    function automatic logic [63:0] tmask(input int g);
        return (64'd1 << cfg_t(g)) - 64'd1;
    endfunction

    // Reference: plain wide arithmetic, borrow from the magnitude comparison
    function automatic logic [63:0] model(input int g, input logic [63:0] a, input logic [63:0] b, input bit sub);
        if (sub) return ((a < b) ? (64'd1 << cfg_w(g)) : 64'd0) | ((a - b) & wmask(g));
        return a + b;
    endfunction

    for (genvar g = 0; g < NINST; g++) begin : g_inst
        localparam int unsigned W = cfg_w(g);
        localparam int unsigned S = cfg_s(g);
        localparam int unsigned T = cfg_t(g);

        adder_pipe_if #(.WIDTH(W), .TAG_W(T)) bus ();

        adder_pipe #(.WIDTH(W), .SEG_W(S), .TAG_W(T)) u_dut (
            .clk (clk),
            .rst (rst || drv_lrst[g]),
            .bus (bus)
        );

        assign bus.in_valid  = drv_v[g];
        assign bus.in_a      = W'(drv_a[g]);
        assign bus.in_b      = W'(drv_b[g]);
        assign bus.in_sub    = drv_sub[g];
        assign bus.in_tag    = T'(drv_tag[g]);
        assign bus.out_ready = drv_ordy[g];
        assign mon_iready[g] = bus.in_ready;
        assign mon_ov[g]     = bus.out_valid;
        assign mon_sum[g]    = 64'(bus.out_sum);
        assign mon_tag[g]    = 64'(bus.out_tag);
    end

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h required %0h", name, got, exp);
        end
    endtask

    // One cycle: drive at negedge, then check handshake, hold, deliver and record accept
    task automatic step(input int g, input bit v, input logic [63:0] a, input logic [63:0] b, input bit sub,
                        input logic [63:0] tg, input bit ordy, input bit use_exp, input logic [63:0] exp_sum,
                        input bit lat);
        exp_t e;
        @(negedge clk);
        drv_v[g]    = v;
        drv_a[g]    = a & wmask(g);
        drv_b[g]    = b & wmask(g);
        drv_sub[g]  = sub;
        drv_tag[g]  = tg & tmask(g);
        drv_ordy[g] = ordy;
        #1;
        check_eq($sformatf("g%0d.in_ready", g), 64'(mon_iready[g]), 64'(!mon_ov[g] || drv_ordy[g]));
        if (hold_prev) begin
            check_eq($sformatf("g%0d.hold_sum", g), mon_sum[g], prev_sum);
            check_eq($sformatf("g%0d.hold_tag", g), mon_tag[g], prev_tag);
        end
        if (mon_ov[g] && drv_ordy[g]) begin
            if (q.size() == 0) begin
                check_eq($sformatf("g%0d.spurious", g), 64'(mon_ov[g]), 64'd0);
            end else begin
                e = q.pop_front();
                check_eq($sformatf("g%0d.sum", g), mon_sum[g], e.sum);
                check_eq($sformatf("g%0d.tag", g), mon_tag[g], e.tag);
                if (e.lat) check_eq($sformatf("g%0d.latency", g), 64'(cyc - e.cyc), 64'(cfg_stg(g)));
            end
        end
        if (v && mon_iready[g]) begin
            e.sum = use_exp ? exp_sum : model(g, a & wmask(g), b & wmask(g), sub);
            e.tag = tg & tmask(g);
            e.cyc = cyc;
            e.lat = lat;
            q.push_back(e);
        end
        hold_prev = mon_ov[g] && !drv_ordy[g];
        prev_sum  = mon_sum[g];
        prev_tag  = mon_tag[g];
        cyc++;
    endtask

    task automatic drain(input int g);
        for (int i = 0; i < 200 && q.size() != 0; i++) step(g, 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        check_eq($sformatf("g%0d.drain_left", g), 64'(q.size()), 64'd0);
    endtask

    task automatic stream(input int g);
        hold_prev = 1'b0;
        for (int i = 0; i < 64; i++)
            step(g, 1'b1, 64'($urandom), 64'($urandom), 1'($urandom_range(0, 1)), 64'(i), 1'b1, 1'b0, '0, 1'b1);
        drain(g);
    endtask

    initial begin
        rst = 1'b1;
        for (int g = 0; g < NINST; g++) begin
            drv_v[g] = 1'b0; drv_sub[g] = 1'b0; drv_ordy[g] = 1'b1; drv_lrst[g] = 1'b0;
            drv_a[g] = '0;   drv_b[g] = '0;     drv_tag[g] = '0;
        end
        #2;
        for (int g = 0; g < NINST; g++) begin
            check_eq($sformatf("g%0d.rst_in_ready", g), 64'(mon_iready[g]), 64'd1);
            check_eq($sformatf("g%0d.rst_out_valid", g), 64'(mon_ov[g]), 64'd0);
            check_eq($sformatf("g%0d.rst_out_sum", g), mon_sum[g], 64'd0);
            check_eq($sformatf("g%0d.rst_out_tag", g), mon_tag[g], 64'd0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Full carry ripple, then the three subtraction corner cases back to back
        step(0, 1'b1, 64'h7FF, 64'h001, 1'b0, 64'd3, 1'b1, 1'b1, 64'h800, 1'b1);
        drain(0);
        step(0, 1'b1, 64'h005, 64'h007, 1'b1, 64'd4, 1'b1, 1'b1, 64'hFFE, 1'b1);
        step(0, 1'b1, 64'h007, 64'h005, 1'b1, 64'd5, 1'b1, 1'b1, 64'h002, 1'b1);
        step(0, 1'b1, 64'h400, 64'h400, 1'b1, 64'd6, 1'b1, 1'b1, 64'h000, 1'b1);
        drain(0);

        for (int g = 0; g < NINST; g++) stream(g);

        // Random backpressure with gaps in the input stream
        hold_prev = 1'b0;
        for (int i = 0; i < 120; i++)
            step(0, 1'($urandom_range(0, 3) != 0), 64'($urandom), 64'($urandom), 1'($urandom_range(0, 1)),
                 64'(i), 1'($urandom_range(0, 1)), 1'b0, '0, 1'b0);
        drain(0);

        // Reset between edges once the first of three operations has reached the output
        for (int i = 0; i < 3; i++)
            step(0, 1'b1, 64'(10 + i), 64'(20 + i), 1'b0, 64'(i), 1'b1, 1'b0, '0, 1'b0);
        @(posedge clk);
        #2;
        check_eq("g0.pre_rst_valid", 64'(mon_ov[0]), 64'd1);
        drv_lrst[0] = 1'b1;
        #1;
        check_eq("g0.rst_drop_valid", 64'(mon_ov[0]), 64'd0);
        q.delete();
        hold_prev = 1'b0;
        repeat (2) step(0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        drv_lrst[0] = 1'b0;
        repeat (6) step(0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        check_eq("g0.post_rst_idle", 64'(mon_ov[0]), 64'd0);
        step(0, 1'b1, 64'd1, 64'd1, 1'b0, 64'd9, 1'b1, 1'b1, 64'h002, 1'b1);
        drain(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/adder_pipe.md
# adder_pipe

Parametrised, pipelined unsigned adder/subtractor for the arithmetic datapath. It generalises the fixed 11-bit ripple-carry adder to any width. The carry chain is cut into SEG_W-bit segments with one register stage per segment. A per-operation add/sub mode, a sideband tag, and valid/ready flow control with backpressure are included. It sits between operand producers and downstream accumulate/compare logic wherever an 11+ bit carry chain would limit clock frequency.

## Interface
- WIDTH, default 11: operand width in bits, ≥ 1.
- SEG_W, default 4: bits resolved per pipeline stage, 1 ≤ SEG_W ≤ WIDTH.
- TAG_W, default 4: sideband tag width, ≥ 1, carried unchanged alongside the operation.
- Derived constant STAGES = ceil(WIDTH/SEG_W). Defaults give 3 stages of 4, 4 and 3 bits.

- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operation offered.
- in_ready  out  1  block accepts the operation this cycle.
- in_a  in  WIDTH  operand A, unsigned.
- in_b  in  WIDTH  operand B, unsigned.
- in_sub  in  1  0 = A+B, 1 = A−B.
- in_tag  in  TAG_W  sideband, returned with the result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH+1  result; see Operation.
- out_tag  out  TAG_W  tag of the operation in out_sum.

## Operation
- Accept occurs when in_valid && in_ready. Deliver occurs when out_valid && out_ready.
- Arithmetic, all unsigned:
  - Add: out_sum = in_a + in_b, full WIDTH+1 bits. Bit WIDTH is the carry out.
  - Sub: out_sum[WIDTH-1:0] = (in_a − in_b) mod 2^WIDTH. out_sum[WIDTH] = 1 iff in_a < in_b (borrow).
  - Sub is implemented as A + ~B with carry-in 1; borrow = ~carry_out.
- Stage k (0-based) adds operand bits [k·SEG_W, min((k+1)·SEG_W, WIDTH)−1] using the carry registered from stage k−1. Stage 0 uses carry-in = in_sub.
- Each stage register holds:
  - a valid bit,
  - the completed lower sum bits,
  - the still-unprocessed upper operand bits, already B-inverted for sub,
  - the carry, mode and tag.
- The final stage register drives out_sum, out_tag and out_valid directly. There is no combinational path from in_* to out_*.
- Global stall: advance = !out_valid || out_ready.
  - in_ready = advance.
  - All stage registers load only when advance = 1.
  - Bubbles are not collapsed.
- A valid operation is never dropped or duplicated. Results leave in acceptance order with their own tag.
- When advance = 1 and in_valid = 0, stage 0 loads valid = 0. Data fields of invalid stages are don't-care.
- STAGES = 1 degenerates to a single registered adder with the same handshake.

## Timing
- Reset values: out_valid = 0, out_sum = 0, out_tag = 0, all internal valid bits 0, carries 0. in_ready = 1 during and after reset, because advance = 1.
- Reset asserted mid-operation discards every in-flight operation immediately. Nothing is emitted after release until new accepts.
- Latency: an operation accepted on edge n is presented on out_* after edge n+STAGES−1. It is visible during the cycle following that edge. With defaults, accept at edge 0 gives out_valid high after edge 2, i.e. 3 register stages.
- Throughput: one operation per cycle while out_ready = 1.
- out_ready low with out_valid high:
  - out_sum and out_tag hold stable.
  - in_ready = 0; the whole pipe freezes.
- out_ready low with out_valid low: the pipe still advances, filling toward the output.
- Simultaneous deliver and accept in the same cycle is legal and required for full throughput.
- out_valid may fall only after a deliver. Output fields may change only after a deliver or while out_valid = 0.

## Test plan
Defaults apply (WIDTH=11, SEG_W=4), unless stated.
- Carry ripple across all segments: add 0x7FF + 0x001, tag 3 → out_sum = 12'h800, out_tag = 3, exactly STAGES cycles after accept.
- Subtract with borrow: 5 − 7 → 12'hFFE. Then 7 − 5 → 12'h002. Then 0x400 − 0x400 → 12'h000.
- Back-to-back streaming:
  - Drive 64 random add/sub operations with out_ready = 1 and distinct tags.
  - Required: one result per cycle, in order, matching the reference model.
  - Required: in_ready constantly 1.
- Backpressure:
  - Stream with out_ready driven by a random 50% pattern.
  - Required: no loss or duplication.
  - Required: out_sum and out_tag stable while out_valid && !out_ready.
  - Required: in_ready == (!out_valid || out_ready) every cycle.
- Reset mid-flight:
  - Accept 3 operations, then assert rst asynchronously between edges.
  - Required: out_valid drops immediately; no stale result appears after release.
  - Required: the next accepted 1 + 1 returns 12'h002.
- Parameter sweep: re-run the streaming test at (WIDTH,SEG_W) = (11,11), (11,1), (16,4), (1,1) against the reference model, with latency = ceil(WIDTH/SEG_W).
